// File: rtl/mlp_sample_sequencer.sv
// Feature-beat sequencer for a combinational MLP classifier: loads a sample beat by beat,
// waits for the classifier to settle, then holds the captured class until downstream accepts it.
module mlp_sample_sequencer #(
    parameter int NUM_A         = 8,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic                       feat_ready,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       res_valid,
    output logic [OUTWIDTH-1:0]        res_data,
    output logic                       res_err,
    input  logic                       res_ready,
    output logic [15:0]                sample_cnt
);

    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_A - 1);
    localparam logic [7:0]       SETTLE_END = 8'(SETTLE_CYCLES);

    logic [1:0]                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
    logic                       err_q, err_d;
    logic                       res_valid_q, res_valid_d;
    logic [OUTWIDTH-1:0]        res_data_q, res_data_d;
    logic                       res_err_q, res_err_d;
    logic [15:0]                sample_cnt_q, sample_cnt_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        inp_d        = inp_q;
        err_d        = err_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        sample_cnt_d = sample_cnt_q;

        case (state_q)
            ST_LOAD: begin
                if (feat_valid) begin
                    for (int k = 0; k < NUM_A; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            inp_d[k*WIDTH_A +: WIDTH_A] = feat_data;
                        end
                    end
                    // Either a missing or a premature last marker is a framing error;
                    // a premature one truncates the sample, leaving later fields zero.
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                        if (!feat_last) begin
                            err_d = 1'b1;
                        end
                    end else if (feat_last) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                // Capture lands SETTLE_CYCLES+1 edges after the final beat.
                if (cnt_q == SETTLE_END) begin
                    cnt_d       = '0;
                    res_data_d  = mlp_out;
                    res_err_d   = err_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d  = 1'b0;
                    sample_cnt_d = sample_cnt_q + 16'd1;
                    err_d        = 1'b0;
                    inp_d        = '0;
                    state_d      = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            idx_q        <= '0;
            cnt_q        <= '0;
            inp_q        <= '0;
            err_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            inp_q        <= inp_d;
            err_q        <= err_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign feat_ready = (state_q == ST_LOAD);
    assign mlp_inp    = inp_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: doc/mlp_sample_sequencer.md
MLP_SAMPLE_SEQUENCER -- requirements
Module: mlp_sample_sequencer

Interface
REQ-001 SHALL have parameter NUM_A, default 8: number of input features per sample.
REQ-002 SHALL have parameter WIDTH_A, default 4: bits per feature.
REQ-003 SHALL have parameter OUTWIDTH, default 2: classifier output width.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..255: clock cycles allowed for the combinational classifier to settle.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 feat_valid  input  1  feature beat valid.
REQ-009 feat_data  input  WIDTH_A  feature value.
REQ-010 feat_last  input  1  marks final feature beat of a sample.
REQ-011 feat_ready  output  1  sequencer accepts a feature beat.
REQ-012 mlp_inp  output  NUM_A*WIDTH_A  packed feature vector to classifier.
REQ-013 mlp_out  input  OUTWIDTH  classifier result (combinational from mlp_inp).
REQ-014 res_valid  output  1  result available.
REQ-015 res_data  output  OUTWIDTH  captured class.
REQ-016 res_err  output  1  framing error on this sample.
REQ-017 res_ready  input  1  downstream accepts result.
REQ-018 sample_cnt  output  16  count of results accepted downstream.

Function
REQ-019 SHALL implement states LOAD, SETTLE, HOLD.
REQ-020 LOAD: feat_ready=1; beat transfers when feat_valid and feat_ready high on a rising edge.
REQ-021 Beat k (k=0..NUM_A-1) SHALL write mlp_inp[(k+1)*WIDTH_A-1 : k*WIDTH_A]; first beat is feature 0.
REQ-022 Beat index SHALL increment per transfer; after beat NUM_A-1, index returns to 0 and state moves to SETTLE.
REQ-023 Framing: err flag SHALL set if feat_last=1 on beat index < NUM_A-1 (sample then truncated: remaining features zero, move to SETTLE) or feat_last=0 on beat NUM_A-1 (sample completes normally, flag set).
REQ-024 mlp_inp SHALL be held stable from SETTLE entry until HOLD exit; unwritten feature fields after truncation SHALL be zero.
REQ-025 SETTLE: feat_ready=0; settle counter SHALL count SETTLE_CYCLES cycles, then capture mlp_out into res_data and enter HOLD.
REQ-026 Capture latency SHALL be exactly SETTLE_CYCLES+1 rising edges after the final beat transfer edge, res_valid high that cycle.
REQ-027 HOLD: res_valid=1, res_data and res_err stable until handshake; feat_ready=0.
REQ-028 Result handshake completes on rising edge with res_valid and res_ready high; SHALL then clear res_valid, increment sample_cnt, clear err flag and mlp_inp to zero, return to LOAD.
REQ-029 sample_cnt SHALL wrap from 16'hFFFF to 0.
REQ-030 res_ready high while res_valid low SHALL have no effect.
REQ-031 feat_valid high outside LOAD SHALL be ignored; no beat consumed.
REQ-032 feat_data, feat_last SHALL be sampled only on transfer edges.
REQ-033 Throughput: one sample per NUM_A+SETTLE_CYCLES+2 cycles minimum with continuous valid/ready.

Reset
REQ-034 rst high at rising edge SHALL force state LOAD, beat index 0, settle count 0, mlp_inp=0, res_valid=0, res_data=0, res_err=0, sample_cnt=0; feat_ready=1 the cycle after reset deasserts.
REQ-035 rst SHALL take priority over every handshake, including mid-LOAD, mid-SETTLE and a same-edge result handshake (sample_cnt not incremented).
REQ-036 Outputs SHALL depend only on registered state (no combinational path input to output).

Verification
REQ-037 Stream 8 beats 1,2,...,8, feat_last on beat 8, model mlp_out = inp[1:0] -> mlp_inp=32'h87654321, res_valid exactly 5 cycles after last beat edge, res_data=1, res_err=0.
REQ-038 feat_last on beat 3 of values 5,5,5 -> mlp_inp=32'h00000555, res_err=1, then next clean sample gives res_err=0.
REQ-039 Hold res_ready=0 for 20 cycles in HOLD with feat_valid=1 -> res_data stable, feat_ready=0, no beats consumed; release -> sample_cnt increments by 1.
REQ-040 Assert rst in SETTLE after full load -> all outputs zero next cycle, no result emitted, sample_cnt=0.
REQ-041 Preload sample_cnt to 16'hFFFF via 65535 samples (or force), complete one more -> sample_cnt=0.
REQ-042 Random valid/ready gaps over 1000 samples vs. reference model -> every result matches, count equals accepted samples.
